demux32_buf: RTL and testbench
==============================

// Module: demux32_buf
// PURPOSE
//  Buffered 1-to-4 32-bit demultiplexer. It is the distribution-side counterpart of the 4:1 source mux.
//  One producer (ALU/writeback result) is steered by in_sel to one of four consumer channels A..D.
//  Each channel holds a 2-entry FIFO with valid/ready handshake, so a stalled consumer does not
//  block traffic bound for the other channels.
// PARAMETERS
//  WIDTH   32  data width of input and of every channel output
//  DEPTH    2  entries per channel FIFO (fixed at 2; count is 2 bits)
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  rst_f       in   1      asynchronous, active-low reset
//  in_data     in   WIDTH  producer data
//  in_sel      in   2      destination: 00=A 01=B 10=C 11=D
//  in_valid    in   1      producer offers in_data/in_sel this cycle
//  in_ready    out  1      selected channel can accept this cycle
//  out_a       out  WIDTH  channel A head data (out_b, out_c, out_d identical for B, C, D)
//  out_valid   out  4      per-channel head valid, bit0=A .. bit3=D
//  out_ready   in   4      per-channel consumer accept, bit0=A .. bit3=D
//  count_a..d  out  2      per-channel occupancy 0..2 (status/debug)
// BEHAVIOUR
//  - Reset (rst_f=0, async): every FIFO is emptied. out_valid=4'b0000, out_a..d=0, count_*=0.
//    in_ready=1 once reset is released. Reset mid-transfer discards all buffered data.
//  - Input transfer occurs when in_valid & in_ready at the clk edge. Only channel in_sel is written.
//  - in_ready = (count[in_sel] != 2). It is combinational from in_sel and the registered count only.
//    It never depends on out_ready (no comb path consumer->producer). It is defined even when in_valid=0.
//  - Output transfer on channel k occurs when out_valid[k] & out_ready[k] at the clk edge.
//  - out_valid[k] = (count_k != 0). out_k is the registered head entry and is stable while valid & !ready.
//  - Latency: a word accepted at edge N appears on out_k with out_valid[k]=1 after edge N (1 cycle).
//    There is no same-cycle pass-through.
//  - Per-channel state EMPTY(0) / ONE(1) / TWO(2):
//    EMPTY: push -> ONE
//    ONE:   push only -> TWO; pop only -> EMPTY; push+pop -> ONE (new word becomes head)
//    TWO:   pop -> ONE (second entry becomes head). Push is impossible because in_ready=0.
//  - Ordering: strict FIFO order within a channel. There is no ordering guarantee across channels.
//  - Channels are independent: pops on any subset of channels may occur in the same cycle as one push.
//  - When a channel is full, a push to it stalls the producer even if the consumer pops that cycle.
//    in_ready rises on the cycle after the pop.
//  - out_k when out_valid[k]=0 holds its last value (0 after reset). Consumers must ignore it.
//  - The module has no X-propagation handling; in_sel is fully decoded (all 4 codes legal).
// STRUCTURE
//  - Shared package/header: channel encodings CH_A=2'b00 .. CH_D=2'b11, the DEPTH constant,
//    and the occupancy codes EMPTY/ONE/TWO.
//  - Sub-module demux_chan_fifo (clk, rst_f, push, wdata, pop, rdata, valid, full, count),
//    instantiated 4 times.
//  - Top level contains the sel decode (push_k = in_valid & in_ready & in_sel==k) and the in_ready mux.
// TESTING
//  1 Reset: assert rst_f=0 mid-run with count_b=2 -> out_valid=0000, count_*=0, out_*=0
//    immediately (async), and in_ready=1 after release.
//  2 Steering: push 32'hDEAD_BEEF sel=10, all out_ready=0 -> next cycle out_valid=0100,
//    out_c=DEAD_BEEF, count_c=1, other counts 0.
//  3 Backpressure: push 11111111 then 22222222 to A with out_ready[0]=0 -> count_a=2 and
//    in_ready=0 for sel=00 but 1 for sel=01. A third push to A stalls. out_a holds 11111111.
//  4 Order + simultaneous: with A in state ONE (head 11111111), push 33333333 to A and pop A
//    in the same cycle -> count_a stays 1 and out_a=33333333 next cycle.
//  5 Full pop: with A in state TWO, out_ready[0]=1 and in_valid=1 sel=00 -> no input transfer
//    that cycle. Next cycle count_a=1 and in_ready=1.
//  6 Independence: fill D to 2 and stall it, then stream 8 words to B with out_ready[1]=1
//    -> all 8 words emerge on B in order with no loss; D is unchanged.

Source files
------------

// File: rtl/demux32_buf_pkg.sv
// Shared definitions for the buffered 1-to-4 demultiplexer: channel codes,
// occupancy codes and FIFO geometry.
package demux32_buf_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;
    localparam int NUM_CH = 4;

    typedef logic [1:0] chan_t;
    typedef logic [1:0] occ_t;

    localparam chan_t CH_A = 2'b00;
    localparam chan_t CH_B = 2'b01;
    localparam chan_t CH_C = 2'b10;
    localparam chan_t CH_D = 2'b11;

    localparam occ_t EMPTY = 2'd0;
    localparam occ_t ONE   = 2'd1;
    localparam occ_t TWO   = 2'd2;

    function automatic logic [NUM_CH-1:0] chan_onehot(input chan_t ch);
        logic [NUM_CH-1:0] oh;
        case (ch)
            CH_A:    oh = 4'b0001;
            CH_B:    oh = 4'b0010;
            CH_C:    oh = 4'b0100;
            CH_D:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux32_buf_if.sv
// Producer/consumer bus of the buffered demultiplexer. The design side uses
// the slave modport; whoever drives producer data and consumer accepts uses master.
interface demux32_buf_if
    import demux32_buf_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_c;
    logic [WIDTH-1:0] out_d;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [1:0]       count_a;
    logic [1:0]       count_b;
    logic [1:0]       count_c;
    logic [1:0]       count_d;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_a, out_b, out_c, out_d, out_valid,
               count_a, count_b, count_c, count_d
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_a, out_b, out_c, out_d, out_valid,
               count_a, count_b, count_c, count_d
    );

endinterface

// File: rtl/demux32_buf_chan_fifo.sv
// Two-entry per-channel FIFO with a registered head word; the head holds its
// last value once the FIFO drains.
module demux_chan_fifo
    import demux32_buf_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic             full_o,
    output occ_t             count_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    occ_t             count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push_i & (count_q != TWO);
    assign pop_ok_s  = pop_i & (count_q != EMPTY);

    // Occupancy transitions; a push coinciding with a pop in ONE replaces the head
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            EMPTY: begin
                if (push_ok_s) begin
                    head_d  = wdata_i;
                    count_d = ONE;
                end else begin
                    count_d = EMPTY;
                end
            end
            ONE: begin
                case ({push_ok_s, pop_ok_s})
                    2'b10: begin
                        tail_d  = wdata_i;
                        count_d = TWO;
                    end
                    2'b01:   count_d = EMPTY;
                    2'b11:   head_d  = wdata_i;
                    default: count_d = ONE;
                endcase
            end
            TWO: begin
                if (pop_ok_s) begin
                    head_d  = tail_q;
                    count_d = ONE;
                end else begin
                    count_d = TWO;
                end
            end
            default: count_d = EMPTY;
        endcase
    end

    // FIFO storage and occupancy registers
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            head_q  <= {WIDTH{1'b0}};
            tail_q  <= {WIDTH{1'b0}};
            count_q <= EMPTY;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign rdata_o = head_q;
    assign valid_o = (count_q != EMPTY);
    assign full_o  = (count_q == TWO);
    assign count_o = count_q;

endmodule

// File: rtl/demux32_buf.sv
// Buffered 1-to-4 demultiplexer: the producer word is steered by in_sel into one
// of four independent two-entry channel FIFOs.
module demux32_buf
    import demux32_buf_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic          clk,
    input  logic          rst_f,
    demux32_buf_if.slave  bus
);

    logic [WIDTH-1:0]  rdata_s [NUM_CH];
    occ_t              count_s [NUM_CH];
    logic [NUM_CH-1:0] valid_s;
    logic [NUM_CH-1:0] full_s;
    logic [NUM_CH-1:0] push_s;
    logic [NUM_CH-1:0] pop_s;
    logic              in_ready_s;

    // Ready looks only at the registered fullness of the selected channel
    always_comb begin
        in_ready_s = 1'b0;
        case (bus.in_sel)
            CH_A:    in_ready_s = ~full_s[0];
            CH_B:    in_ready_s = ~full_s[1];
            CH_C:    in_ready_s = ~full_s[2];
            CH_D:    in_ready_s = ~full_s[3];
            default: in_ready_s = 1'b0;
        endcase
    end

    // Destination decode: only an accepted transfer writes a channel
    always_comb begin
        push_s = 4'b0000;
        if (bus.in_valid && in_ready_s) begin
            push_s = chan_onehot(bus.in_sel);
        end else begin
            push_s = 4'b0000;
        end
    end

    assign pop_s = bus.out_ready & valid_s;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        demux_chan_fifo #(
            .WIDTH (WIDTH)
        ) u_fifo (
            .clk     (clk),
            .rst_f   (rst_f),
            .push_i  (push_s[i]),
            .wdata_i (bus.in_data),
            .pop_i   (pop_s[i]),
            .rdata_o (rdata_s[i]),
            .valid_o (valid_s[i]),
            .full_o  (full_s[i]),
            .count_o (count_s[i])
        );
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = valid_s;
    assign bus.out_a     = rdata_s[0];
    assign bus.out_b     = rdata_s[1];
    assign bus.out_c     = rdata_s[2];
    assign bus.out_d     = rdata_s[3];
    assign bus.count_a   = count_s[0];
    assign bus.count_b   = count_s[1];
    assign bus.count_c   = count_s[2];
    assign bus.count_d   = count_s[3];

endmodule

// File: tb/tb_demux32_buf.sv
// Self-checking bench for demux32_buf: directed scenarios followed by random
// traffic, all compared against per-channel queues holding the expected contents.
module tb_demux32_buf;
    import demux32_buf_pkg::*;

    logic clk   = 1'b0;
    logic rst_f = 1'b0;

    always #5 clk = ~clk;

    demux32_buf_if #(.WIDTH(32)) bus ();

    demux32_buf #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] q_m [4][$];
    logic [31:0] last_m [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dut_out(input int k);
        case (k)
            0:       return bus.out_a;
            1:       return bus.out_b;
            2:       return bus.out_c;
            default: return bus.out_d;
        endcase
    endfunction

    function automatic logic [31:0] dut_count(input int k);
        case (k)
            0:       return 32'(bus.count_a);
            1:       return 32'(bus.count_b);
            2:       return 32'(bus.count_c);
            default: return 32'(bus.count_d);
        endcase
    endfunction

    task automatic compare_all(input string tag);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_valid%0d", tag, k), 32'(bus.out_valid[k]), 32'(q_m[k].size() != 0));
            check($sformatf("%s_out%0d", tag, k), dut_out(k), last_m[k]);
            check($sformatf("%s_count%0d", tag, k), dut_count(k), 32'(q_m[k].size()));
        end
        check($sformatf("%s_in_ready", tag), 32'(bus.in_ready), 32'(q_m[bus.in_sel].size() != 2));
    endtask

    // One clock: drive at the falling edge, compare, then apply the accepted transfers to the model
    task automatic cycle(input logic v, input logic [1:0] sel, input logic [31:0] d,
                         input logic [3:0] rdy, input string tag);
        logic       push;
        logic [3:0] pop;
        bus.in_valid  = v;
        bus.in_sel    = sel;
        bus.in_data   = d;
        bus.out_ready = rdy;
        #1;
        compare_all(tag);
        push = v && (q_m[sel].size() < 2);
        for (int k = 0; k < 4; k++) pop[k] = rdy[k] && (q_m[k].size() > 0);
        @(posedge clk);
        for (int k = 0; k < 4; k++) if (pop[k]) void'(q_m[k].pop_front());
        if (push) q_m[sel].push_back(d);
        for (int k = 0; k < 4; k++) if (q_m[k].size() > 0) last_m[k] = q_m[k][0];
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            q_m[k].delete();
            last_m[k] = 32'h0;
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'b00;
        bus.in_data   = 32'h0;
        bus.out_ready = 4'b0000;
        model_reset();
        #12;
        compare_all("por");
        @(negedge clk);
        rst_f = 1'b1;
        #1;
        check("por_in_ready", 32'(bus.in_ready), 32'h1);

        cycle(1'b1, 2'b10, 32'hDEAD_BEEF, 4'b0000, "steer_push");
        #1;
        check("steer_valid", 32'(bus.out_valid), 32'h4);
        check("steer_out_c", bus.out_c, 32'hDEAD_BEEF);
        check("steer_count_c", 32'(bus.count_c), 32'h1);
        cycle(1'b0, 2'b00, 32'h0, 4'b0100, "steer_drain");

        cycle(1'b1, 2'b00, 32'h1111_1111, 4'b0000, "a_first");
        cycle(1'b1, 2'b00, 32'h3333_3333, 4'b0001, "a_pushpop");
        #1;
        check("pushpop_count_a", 32'(bus.count_a), 32'h1);
        check("pushpop_out_a", bus.out_a, 32'h3333_3333);

        cycle(1'b1, 2'b00, 32'h2222_2222, 4'b0000, "a_fill");
        cycle(1'b1, 2'b00, 32'h5555_5555, 4'b0000, "a_stall");
        bus.in_sel = 2'b01;
        #1;
        check("bp_in_ready_b", 32'(bus.in_ready), 32'h1);
        check("bp_count_a", 32'(bus.count_a), 32'h2);
        check("bp_out_a", bus.out_a, 32'h3333_3333);

        cycle(1'b1, 2'b00, 32'h4444_4444, 4'b0001, "full_pop");
        #1;
        check("fullpop_count_a", 32'(bus.count_a), 32'h1);
        check("fullpop_out_a", bus.out_a, 32'h2222_2222);
        bus.in_sel = 2'b00;
        #1;
        check("fullpop_in_ready", 32'(bus.in_ready), 32'h1);
        cycle(1'b0, 2'b00, 32'h0, 4'b0001, "a_drain");

        cycle(1'b1, 2'b11, 32'hD000_0001, 4'b0000, "d_fill0");
        cycle(1'b1, 2'b11, 32'hD000_0002, 4'b0000, "d_fill1");
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 2'b01, 32'hB000_0000 + 32'(i), 4'b0010, "b_stream");
        end
        cycle(1'b0, 2'b01, 32'h0, 4'b0010, "b_drain");
        cycle(1'b0, 2'b01, 32'h0, 4'b0010, "b_drain");
        #1;
        check("indep_count_d", 32'(bus.count_d), 32'h2);
        check("indep_out_d", bus.out_d, 32'hD000_0001);
        check("indep_out_b_last", bus.out_b, 32'hB000_0007);

        cycle(1'b1, 2'b01, 32'hB100_0000, 4'b0000, "b_fill0");
        cycle(1'b1, 2'b01, 32'hB100_0001, 4'b0000, "b_fill1");
        #1;
        check("prerst_count_b", 32'(bus.count_b), 32'h2);
        #2;
        rst_f = 1'b0;
        #1;
        model_reset();
        compare_all("rst_async");
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        @(negedge clk);
        rst_f = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);

        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
                  4'($urandom_range(0, 15)), "rand");
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 2'b00, 32'h0, 4'b1111, "final_drain");
        end
        #1;
        compare_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
